// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Sequential RV32I instruction encoder and instruction-memory loader.
// Symbolic instructions (operation index + register/immediate fields) are
// accepted over a valid/ready handshake, assembled into 32-bit machine words
// and written to consecutive instruction-memory word addresses. This is the
// inverse of the core's control-decode path; it fills the single-cycle core's
// instruction memory before the core is released.
//
// Ports
//   clk         in   clock, all state updates on the rising edge
//   rst         in   synchronous active-high reset
//   in_valid    in   instruction fields valid
//   in_ready    out  block can accept an instruction (IDLE and not full)
//   in_last     in   final instruction of a program
//   op          in   5-bit operation index (0-25 legal, 26-31 illegal)
//   rd/rs1/rs2  in   register numbers
//   imm         in   signed byte offset / immediate (full upper value for U-type)
//   imem_we     out  one-cycle instruction-memory write strobe
//   imem_addr   out  word address (write pointer)
//   imem_wdata  out  encoded instruction word
//   illegal     out  one-cycle pulse when an instruction is rejected
//   done        out  one-cycle pulse after the last instruction completes
//   full        out  address space exhausted; sticky until reset
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [4:0]        op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              illegal,
  output logic              done,
  output logic              full
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  // Operation indices
  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_SLL   = 5'd2;
  localparam logic [4:0] OP_SLT   = 5'd3;
  localparam logic [4:0] OP_SLTU  = 5'd4;
  localparam logic [4:0] OP_XOR   = 5'd5;
  localparam logic [4:0] OP_SRL   = 5'd6;
  localparam logic [4:0] OP_SRA   = 5'd7;
  localparam logic [4:0] OP_OR    = 5'd8;
  localparam logic [4:0] OP_AND   = 5'd9;
  localparam logic [4:0] OP_ADDI  = 5'd10;
  localparam logic [4:0] OP_ANDI  = 5'd11;
  localparam logic [4:0] OP_ORI   = 5'd12;
  localparam logic [4:0] OP_XORI  = 5'd13;
  localparam logic [4:0] OP_SLLI  = 5'd14;
  localparam logic [4:0] OP_SRLI  = 5'd15;
  localparam logic [4:0] OP_SRAI  = 5'd16;
  localparam logic [4:0] OP_SLTI  = 5'd17;
  localparam logic [4:0] OP_SLTIU = 5'd18;
  localparam logic [4:0] OP_LW    = 5'd19;
  localparam logic [4:0] OP_SW    = 5'd20;
  localparam logic [4:0] OP_BEQ   = 5'd21;
  localparam logic [4:0] OP_JAL   = 5'd22;
  localparam logic [4:0] OP_JALR  = 5'd23;
  localparam logic [4:0] OP_LUI   = 5'd24;
  localparam logic [4:0] OP_AUIPC = 5'd25;

  // Major opcodes
  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENC   = 2'd1,
    S_WRITE = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Captured instruction fields
  logic [4:0]        r_op;
  logic [4:0]        r_rd;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [31:0]       r_imm;
  logic              r_last;

  // Datapath state
  logic [31:0]       r_wdata;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_full;

  // Combinational encode results
  logic              w_hs;
  logic [2:0]        w_funct3;
  logic [6:0]        w_funct7;
  logic              w_imm12_ok;
  logic              w_shamt_ok;
  logic              w_b_ok;
  logic              w_j_ok;
  logic              w_u_ok;
  logic [31:0]       w_word;
  logic              w_legal;

  assign w_hs = in_valid && (r_state == S_IDLE) && !r_full;

  // ---------------------------------------------------------------------------
  // Immediate range checks. A value fits an N-bit signed field when every bit
  // above the field's sign bit equals that sign bit.
  // ---------------------------------------------------------------------------
  assign w_imm12_ok = (r_imm[31:11] == {21{r_imm[11]}});
  assign w_shamt_ok = (r_imm[31:5] == 27'd0);
  // 13-bit signed, even: -4096..4094
  assign w_b_ok     = !r_imm[0] && (r_imm[31:12] == {20{r_imm[12]}});
  // 21-bit signed, even: -2^20..2^20-2
  assign w_j_ok     = !r_imm[0] && (r_imm[31:20] == {12{r_imm[20]}});
  assign w_u_ok     = (r_imm[11:0] == 12'd0);

  // funct3 / funct7 shared by the R-type and I-ALU groups
  always_comb begin
    w_funct3 = 3'b000;
    w_funct7 = 7'h00;
    case (r_op)
      OP_SLL,  OP_SLLI:  w_funct3 = 3'b001;
      OP_SLT,  OP_SLTI:  w_funct3 = 3'b010;
      OP_SLTU, OP_SLTIU: w_funct3 = 3'b011;
      OP_XOR,  OP_XORI:  w_funct3 = 3'b100;
      OP_SRL,  OP_SRLI,
      OP_SRA,  OP_SRAI:  w_funct3 = 3'b101;
      OP_OR,   OP_ORI:   w_funct3 = 3'b110;
      OP_AND,  OP_ANDI:  w_funct3 = 3'b111;
      default:           w_funct3 = 3'b000;
    endcase
    if (r_op == OP_SUB || r_op == OP_SRA || r_op == OP_SRAI) begin
      w_funct7 = 7'h20;
    end
  end

  // Word assembly and legality
  always_comb begin
    w_word  = 32'd0;
    w_legal = 1'b0;
    if (r_op <= OP_AND) begin
      w_word  = {w_funct7, r_rs2, r_rs1, w_funct3, r_rd, OPC_R};
      w_legal = 1'b1;
    end else if (r_op == OP_SLLI || r_op == OP_SRLI || r_op == OP_SRAI) begin
      w_word  = {w_funct7, r_imm[4:0], r_rs1, w_funct3, r_rd, OPC_I_ALU};
      w_legal = w_shamt_ok;
    end else if (r_op <= OP_SLTIU) begin
      w_word  = {r_imm[11:0], r_rs1, w_funct3, r_rd, OPC_I_ALU};
      w_legal = w_imm12_ok;
    end else begin
      case (r_op)
        OP_LW: begin
          w_word  = {r_imm[11:0], r_rs1, 3'b010, r_rd, OPC_LOAD};
          w_legal = w_imm12_ok;
        end
        OP_SW: begin
          w_word  = {r_imm[11:5], r_rs2, r_rs1, 3'b010, r_imm[4:0], OPC_STORE};
          w_legal = w_imm12_ok;
        end
        OP_BEQ: begin
          w_word  = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, 3'b000,
                     r_imm[4:1], r_imm[11], OPC_BR};
          w_legal = w_b_ok;
        end
        OP_JAL: begin
          w_word  = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12],
                     r_rd, OPC_JAL};
          w_legal = w_j_ok;
        end
        OP_JALR: begin
          w_word  = {r_imm[11:0], r_rs1, 3'b000, r_rd, OPC_JALR};
          w_legal = w_imm12_ok;
        end
        OP_LUI: begin
          w_word  = {r_imm[31:12], r_rd, OPC_LUI};
          w_legal = w_u_ok;
        end
        OP_AUIPC: begin
          w_word  = {r_imm[31:12], r_rd, OPC_AUIPC};
          w_legal = w_u_ok;
        end
        default: begin
          w_word  = 32'd0;
          w_legal = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          w_state_next = S_ENC;
        end
      end
      S_ENC: begin
        if (w_legal) begin
          w_state_next = S_WRITE;
        end else if (r_last) begin
          w_state_next = S_FIN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_WRITE: begin
        w_state_next = r_last ? S_FIN : S_IDLE;
      end
      S_FIN: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // FSM: outputs. Strobes are masked while rst is high so that a reset
  // landing on a WRITE/ENC/FIN cycle never leaks a pulse.
  always_comb begin
    in_ready = (r_state == S_IDLE) && !r_full;
    imem_we  = (r_state == S_WRITE) && !rst;
    illegal  = (r_state == S_ENC) && !w_legal && !rst;
    done     = (r_state == S_FIN) && !rst;
  end

  assign imem_addr  = r_ptr;
  assign imem_wdata = r_wdata;
  assign full       = r_full;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op    <= 5'd0;
      r_rd    <= 5'd0;
      r_rs1   <= 5'd0;
      r_rs2   <= 5'd0;
      r_imm   <= 32'd0;
      r_last  <= 1'b0;
      r_wdata <= 32'd0;
      r_ptr   <= BASE;
      r_full  <= 1'b0;
    end else begin
      if (w_hs) begin
        r_op   <= op;
        r_rd   <= rd;
        r_rs1  <= rs1;
        r_rs2  <= rs2;
        r_imm  <= imm;
        r_last <= in_last;
      end
      // Rejected instructions leave the previous word in place.
      if (r_state == S_ENC && w_legal) begin
        r_wdata <= w_word;
      end
      // The pointer saturates at all-ones; full then blocks further input.
      if (r_state == S_WRITE) begin
        if (&r_ptr) begin
          r_full <= 1'b1;
        end else begin
          r_ptr <= r_ptr + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  // Main instance (ADDR_W = 8, BASE_ADDR = 0)
  logic        in_valid, in_ready, in_last;
  logic [4:0]  op, rd, rs1, rs2;
  logic [31:0] imm;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        illegal, done, full;

  // Small instance (ADDR_W = 2) for the full condition
  logic        s_in_valid, s_in_ready, s_in_last;
  logic        s_we;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic        s_illegal, s_done, s_full;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .illegal(illegal), .done(done), .full(full)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_last(s_in_last), .op(5'd0), .rd(5'd1), .rs1(5'd1), .rs2(5'd1),
    .imm(32'd0), .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
    .illegal(s_illegal), .done(s_done), .full(s_full)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t  wr_q[$];
  int   ill_q[$];
  int   done_q[$];

  int   ncnt     = 0;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  logic [7:0] exp_ptr;

  int   s_wr_cnt   = 0;
  int   s_done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    chk_cnt = chk_cnt + 1;
    if (act === exp) begin
      pass_cnt = pass_cnt + 1;
    end else begin
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, ncnt);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  wr_t mon_e;
  int  mon_c;
  always @(negedge clk) begin
    ncnt = ncnt + 1;
    if (imem_we) begin
      $display("write   addr=%0d data=%08h cycle=%0d", imem_addr, imem_wdata, ncnt);
      if (wr_q.size() == 0) begin
        check("unexpected_write", 32'(imem_we), 32'd0);
      end else begin
        mon_e = wr_q.pop_front();
        check("write_addr", 32'(imem_addr), 32'(mon_e.addr));
        check("write_data", imem_wdata, mon_e.data);
        check("write_latency", ncnt, mon_e.cyc);
      end
    end
    if (illegal) begin
      $display("illegal cycle=%0d", ncnt);
      if (ill_q.size() == 0) begin
        check("unexpected_illegal", 32'(illegal), 32'd0);
      end else begin
        mon_c = ill_q.pop_front();
        check("illegal_latency", ncnt, mon_c);
      end
    end
    if (done) begin
      $display("done    cycle=%0d", ncnt);
      if (done_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_c = done_q.pop_front();
        check("done_latency", ncnt, mon_c);
      end
    end
  end

  // Small-instance monitor: writes must land at 0,1,2,3 in order.
  always @(negedge clk) begin
    if (s_we) begin
      $display("s_write addr=%0d data=%08h", s_addr, s_wdata);
      check("s_write_addr", 32'(s_addr), s_wr_cnt);
      s_wr_cnt = s_wr_cnt + 1;
    end
    if (s_done) s_done_cnt = s_done_cnt + 1;
  end

  // Issue one instruction; when tracked, push the expected response.
  task automatic send(input logic [4:0] o, input logic [4:0] d,
                      input logic [4:0] a, input logic [4:0] b,
                      input logic [31:0] im, input bit last,
                      input bit legal, input logic [31:0] word,
                      input bit track);
    int n;
    int h;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    op = o; rd = d; rs1 = a; rs2 = b; imm = im; in_last = last;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n = n + 1;
    end
    if (!in_ready) begin
      check("handshake_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    h = ncnt;
    if (track) begin
      if (legal) begin
        wr_q.push_back('{exp_ptr, word, h + 2});
        exp_ptr = exp_ptr + 8'd1;
        if (last) done_q.push_back(h + 3);
      end else begin
        ill_q.push_back(h + 1);
        if (last) done_q.push_back(h + 2);
      end
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_full", 32'(full), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0;
    op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    s_in_valid = 1'b0; s_in_last = 1'b0;
    exp_ptr = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_values();

    // Basic R/I encodes
    send(5'd0,  5'd3, 5'd1, 5'd2, 32'd5,          1'b0, 1'b1, 32'h002081B3, 1'b1); // ADD
    send(5'd10, 5'd1, 5'd0, 5'd0, 32'd5,          1'b0, 1'b1, 32'h00500093, 1'b1); // ADDI
    // Format coverage
    send(5'd1,  5'd5, 5'd6, 5'd7, 32'd0,          1'b0, 1'b1, 32'h407302B3, 1'b1); // SUB
    send(5'd20, 5'd0, 5'd1, 5'd2, 32'd8,          1'b0, 1'b1, 32'h0020A423, 1'b1); // SW
    send(5'd21, 5'd0, 5'd1, 5'd2, -32'sd4,        1'b0, 1'b1, 32'hFE208EE3, 1'b1); // BEQ
    send(5'd24, 5'd5, 5'd0, 5'd0, 32'h12345000,   1'b0, 1'b1, 32'h123452B7, 1'b1); // LUI
    send(5'd16, 5'd4, 5'd4, 5'd0, 32'd3,          1'b0, 1'b1, 32'h40325213, 1'b1); // SRAI
    send(5'd22, 5'd1, 5'd0, 5'd0, 32'd8,          1'b0, 1'b1, 32'h008000EF, 1'b1); // JAL
    send(5'd19, 5'd6, 5'd2, 5'd0, -32'sd4,        1'b0, 1'b1, 32'hFFC12303, 1'b1); // LW
    send(5'd25, 5'd10, 5'd0, 5'd0, 32'h00001000,  1'b0, 1'b1, 32'h00001517, 1'b1); // AUIPC
    // Illegal rejection
    send(5'd10, 5'd1, 5'd0, 5'd0, 32'd2048,       1'b0, 1'b0, 32'h0, 1'b1);        // ADDI 2048
    send(5'd27, 5'd1, 5'd0, 5'd0, 32'd0,          1'b0, 1'b0, 32'h0, 1'b1);        // op 27
    send(5'd21, 5'd0, 5'd1, 5'd2, 32'd3,          1'b0, 1'b0, 32'h0, 1'b1);        // BEQ odd
    send(5'd14, 5'd1, 5'd1, 5'd0, 32'd32,         1'b0, 1'b0, 32'h0, 1'b1);        // SLLI 32
    send(5'd24, 5'd1, 5'd0, 5'd0, 32'h00000123,   1'b0, 1'b0, 32'h0, 1'b1);        // LUI low bits
    send(5'd5,  5'd1, 5'd2, 5'd3, 32'd0,          1'b0, 1'b1, 32'h003140B3, 1'b1); // XOR
    // Three-instruction program ending with in_last
    send(5'd11, 5'd2, 5'd2, 5'd0, -32'sd1,        1'b0, 1'b1, 32'hFFF17113, 1'b1); // ANDI -1
    send(5'd23, 5'd0, 5'd1, 5'd0, 32'd0,          1'b0, 1'b1, 32'h00008067, 1'b1); // JALR
    send(5'd12, 5'd5, 5'd0, 5'd0, 32'd2047,       1'b1, 1'b1, 32'h7FF06293, 1'b1); // ORI last
    // Illegal last instruction still produces done
    send(5'd10, 5'd1, 5'd0, 5'd0, -32'sd2049,     1'b1, 1'b0, 32'h0, 1'b1);        // ADDI -2049

    // Reset during ENC
    send(5'd0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values();
    exp_ptr = 8'd0;
    send(5'd3, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b1, 32'h003120B3, 1'b1);          // SLT

    repeat (6) @(negedge clk);
    check("write_queue_drained", 32'(wr_q.size()), 32'd0);
    check("illegal_queue_drained", 32'(ill_q.size()), 32'd0);
    check("done_queue_drained", 32'(done_q.size()), 32'd0);

    // Full with ADDR_W = 2
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      s_in_valid = 1'b1;
      s_in_last  = (k == 3);
      n = 0;
      while (!s_in_ready && n < 50) begin
        @(negedge clk);
        n = n + 1;
      end
      check("s_handshake", 32'(s_in_ready), 32'd1);
      @(posedge clk);
      #1;
      s_in_valid = 1'b0;
    end
    repeat (5) @(negedge clk);
    check("s_full_set", 32'(s_full), 32'd1);
    check("s_in_ready_low", 32'(s_in_ready), 32'd0);
    check("s_write_count", s_wr_cnt, 32'd4);
    check("s_done_count", s_done_cnt, 32'd1);
    s_in_valid = 1'b1;
    repeat (10) @(negedge clk);
    check("s_no_write_when_full", s_wr_cnt, 32'd4);
    check("s_in_ready_held_low", 32'(s_in_ready), 32'd0);
    check("s_wdata_last", s_wdata, 32'h001080B3);
    s_in_valid = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV32I instruction encoder and instruction-memory loader. Accepts symbolic instructions (operation index plus register and immediate fields) over a valid/ready handshake, and assembles each one into its 32-bit machine word. Writes the words to consecutive instruction-memory words. Performs the inverse of the core's control-decode path and feeds the single-cycle core's instruction memory before the core runs.

## Interface
- `ADDR_W`, default 8: instruction-memory word-address width.
- `BASE_ADDR`, default 0: first word address written after reset.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: the instruction fields are valid.
- `in_ready`  out  1: the block can accept an instruction.
- `in_last`  in  1: marks the final instruction of a program.
- `op`  in  5: operation index.
  - 0–9: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - 10–18: ADDI, ANDI, ORI, XORI, SLLI, SRLI, SRAI, SLTI, SLTIU.
  - 19–25: LW, SW, BEQ, JAL, JALR, LUI, AUIPC.
  - 26–31: illegal.
- `rd`, `rs1`, `rs2`  in  5 each: register numbers.
- `imm`  in  32: signed byte offset or immediate. For LUI/AUIPC it is the full upper value.
- `imem_we`  out  1: one-cycle write strobe.
- `imem_addr`  out  `ADDR_W`: word address.
- `imem_wdata`  out  32: encoded instruction.
- `illegal`  out  1: one-cycle pulse when an instruction is rejected.
- `done`  out  1: one-cycle pulse after the `in_last` instruction completes.
- `full`  out  1: the address space is exhausted.

## Operation
- FSM states: IDLE, ENC, WRITE, FIN.
- IDLE
  - `in_ready = !full`.
  - A handshake occurs when `in_valid && in_ready`. It registers all fields and `in_last`, then moves to ENC.
- ENC
  - Builds the word into a register. Moves to WRITE if legal; otherwise pulses `illegal` and moves to FIN if `last`, else to IDLE.
- WRITE
  - `imem_we = 1`. The address is driven from the pointer.
  - The pointer increments on exit.
  - `full` is set if the pointer was all-ones; there is no wrap.
  - Moves to FIN if `last`, else to IDLE.
- FIN: `done = 1` for one cycle, then IDLE. The pointer is not reset; the next program appends.
- Encoding formats:
  - R-type: opcode 0110011. funct3 follows RV32I. funct7 = 0x20 for SUB/SRA, else 0x00.
  - I-ALU: opcode 0010011, `imm[11:0]` placed in bits 31:20.
  - Shift-immediates: bits 31:25 = 0x20 for SRAI, else 0x00; bits 24:20 = `imm[4:0]`.
  - LW: opcode 0000011, funct3 010.
  - JALR: opcode 1100111, funct3 000.
  - SW: opcode 0100011, funct3 010, split S-immediate.
  - BEQ: opcode 1100011, funct3 000, B-immediate.
  - JAL: opcode 1101111, J-immediate.
  - LUI/AUIPC: opcodes 0110111/0010111, `imm[31:12]`.
- Illegal conditions (no write, pointer unchanged):
  - `op` ≥ 26.
  - I/S immediate outside −2048..2047.
  - Shift `imm` outside 0..31.
  - BEQ: odd offset, or offset outside −4096..4094.
  - JAL: odd offset, or offset outside −2^20..2^20−2.
  - LUI/AUIPC: `imm[11:0]` ≠ 0.
- Unused fields (e.g. `rs2` for I-type) are ignored.

## Timing
- Reset values: state IDLE, `in_ready` 1, `imem_we` 0, `imem_addr` `BASE_ADDR`, `imem_wdata` 0, `illegal` 0, `done` 0, `full` 0.
- Reset mid-operation drops any pending encode or write. No strobe is issued in the reset cycle or the cycle after it.
- Handshake at edge N: ENC runs during N+1, `imem_we` is high in cycle N+2, `done` is high in N+3 if `last`.
- Throughput is one instruction per 3 cycles, or 4 cycles for a last instruction.
- `in_ready` is low in ENC, WRITE and FIN. Inputs are don't-care outside the handshake.
- `illegal` is high during the ENC cycle (N+1).
- `imem_addr` and `imem_wdata` are stable throughout the `imem_we` cycle.
- When `full` is set, `in_ready` stays low until reset, and `done` still fires for a `last` instruction.

## Test plan
- **Basic R/I encodes:** after reset, send ADD rd3 rs1=1 rs2=2, then ADDI rd1 rs1=0 imm 5 → writes 0x002081B3 at addr 0 and 0x00500093 at addr 1. Each `imem_we` comes exactly 2 cycles after its handshake.
- **Format coverage:** send SUB x5,x6,x7; SW rs2=2 rs1=1 imm 8; BEQ rs1=1 rs2=2 imm −4; LUI rd5 imm 0x12345000 → words 0x407302B3, 0x0020A423, 0xFE208EE3, 0x123452B7 at consecutive addresses.
- **Illegal rejection:** ADDI imm 2048, then op 27, then BEQ imm 3 → three `illegal` pulses, no `imem_we`, pointer unchanged. The next legal instruction lands at the original address.
- **Last and done:** a 3-instruction program with `in_last` on the third → `done` pulses once, one cycle after the third write. The same holds when the last instruction is illegal (`done` one cycle after `illegal`).
- **Full:** with `ADDR_W=2`, write 4 legal words → `full` rises after the write to addr 3, `in_ready` stays 0, and a held `in_valid` causes no writes.
- **Reset mid-operation:** assert `rst` in the ENC cycle → no `imem_we`, and all outputs return to reset values. The next instruction is written at `BASE_ADDR`.
